// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: stalls, bubbles and flushes for load-use, multi-cycle
// multiply, d-cache miss and taken-branch squash, plus a saturating stall-cycle counter.
module hazard_stall_controller #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_rgS1_index_IF_ID,
  input  logic [4:0]       i_rgS2_index_IF_ID,
  input  logic             i_rgS1_used_IF_ID,
  input  logic             i_rgS2_used_IF_ID,
  input  logic [4:0]       i_rgD_index_ID_EX,
  input  logic             i_ID_EX_readMem,
  input  logic             i_ID_EX_writeRg,
  input  logic             i_ID_EX_isMul,
  input  logic             i_branch_taken_EX,
  input  logic             i_dcache_miss_M,
  input  logic             i_dcache_ready,
  output logic             o_stall_F,
  output logic             o_stall_D,
  output logic             o_stall_X,
  output logic             o_stall_M,
  output logic             o_flush_D,
  output logic             o_bubble_X,
  output logic             o_bubble_M,
  output logic             o_bubble_W,
  output logic [1:0]       o_ctrl_state,
  output logic [CNT_W-1:0] o_stall_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MUL_WAIT = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_t;

  localparam int   MC_W      = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam int   MUL_LOAD  = (MUL_LAT > 2) ? (MUL_LAT - 2) : 0;
  localparam logic MUL_STALL = (MUL_LAT > 1) ? 1'b1 : 1'b0;
  // A two-cycle multiply needs only the entry stall, so it never enters MUL_WAIT.
  localparam logic MUL_SHORT = (MUL_LAT == 2) ? 1'b1 : 1'b0;

  state_t            r_state;
  state_t            w_next_state;
  logic [MC_W-1:0]   r_mul_cnt;
  logic [MC_W-1:0]   w_cnt_next;
  logic              r_mul_done;
  logic              w_mul_done_next;
  logic [CNT_W-1:0]  r_stall_count;
  logic              w_load_use;
  logic              w_mul_start;
  logic              w_stall_F, w_stall_D, w_stall_X, w_stall_M;
  logic              w_flush_D, w_bubble_X, w_bubble_M, w_bubble_W;

  assign w_load_use = i_ID_EX_readMem & i_ID_EX_writeRg & (i_rgD_index_ID_EX != 5'd0) &
                      ((i_rgS1_used_IF_ID & (i_rgS1_index_IF_ID == i_rgD_index_ID_EX)) |
                       (i_rgS2_used_IF_ID & (i_rgS2_index_IF_ID == i_rgD_index_ID_EX)));

  assign w_mul_start = i_ID_EX_isMul & ~r_mul_done & MUL_STALL;

  always_comb begin
    w_next_state    = r_state;
    w_cnt_next      = r_mul_cnt;
    w_mul_done_next = r_mul_done;
    w_stall_F       = 1'b0;
    w_stall_D       = 1'b0;
    w_stall_X       = 1'b0;
    w_stall_M       = 1'b0;
    w_flush_D       = 1'b0;
    w_bubble_X      = 1'b0;
    w_bubble_M      = 1'b0;
    w_bubble_W      = 1'b0;
    if (!i_reset) begin
      w_next_state    = ST_RUN;
      w_cnt_next      = '0;
      w_mul_done_next = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_dcache_miss_M) begin
            {w_stall_F, w_stall_D, w_stall_X, w_stall_M, w_bubble_W} = 5'b11111;
            w_next_state = ST_MEM_WAIT;
          end else if (w_mul_start) begin
            {w_stall_F, w_stall_D, w_stall_X, w_bubble_M} = 4'b1111;
            if (MUL_SHORT) begin
              w_next_state = ST_RUN;
            end else begin
              w_cnt_next   = MC_W'(MUL_LOAD);
              w_next_state = ST_MUL_WAIT;
            end
          end else if (i_branch_taken_EX) begin
            {w_flush_D, w_bubble_X} = 2'b11;
          end else if (w_load_use) begin
            {w_stall_F, w_stall_D, w_bubble_X} = 3'b111;
          end else begin
            w_next_state = ST_RUN;
          end
          // mul_done survives only while EX stays held, so a multiply is stalled once.
          w_mul_done_next = (r_mul_done | (w_mul_start & MUL_SHORT & ~i_dcache_miss_M)) & w_stall_X;
        end
        ST_MUL_WAIT: begin
          {w_stall_F, w_stall_D, w_stall_X, w_bubble_M} = 4'b1111;
          w_cnt_next = r_mul_cnt - MC_W'(1);
          if (w_cnt_next == '0) begin
            w_next_state    = ST_RUN;
            w_mul_done_next = 1'b1;
          end else begin
            w_next_state = ST_MUL_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          {w_stall_F, w_stall_D, w_stall_X, w_stall_M, w_bubble_W} = 5'b11111;
          if (i_dcache_ready) begin
            w_next_state = ST_RUN;
          end else begin
            w_next_state = ST_MEM_WAIT;
          end
        end
        default: begin
          w_next_state    = ST_RUN;
          w_cnt_next      = '0;
          w_mul_done_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= ST_RUN;
      r_mul_cnt     <= '0;
      r_mul_done    <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state    <= w_next_state;
      r_mul_cnt  <= w_cnt_next;
      r_mul_done <= w_mul_done_next;
      if (w_stall_F && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end else begin
        r_stall_count <= r_stall_count;
      end
    end
  end

  assign o_stall_F     = w_stall_F;
  assign o_stall_D     = w_stall_D;
  assign o_stall_X     = w_stall_X;
  assign o_stall_M     = w_stall_M;
  assign o_flush_D     = w_flush_D;
  assign o_bubble_X    = w_bubble_X;
  assign o_bubble_M    = w_bubble_M;
  assign o_bubble_W    = w_bubble_W;
  assign o_ctrl_state  = r_state;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: a 32-bit-counter instance and a
// 4-bit-counter instance share one stimulus stream.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] s1_idx, s2_idx, rd_idx;
  logic       s1_used, s2_used, rd_mem, wr_rg, is_mul, br_taken, miss, ready;

  logic        a_sF, a_sD, a_sX, a_sM, a_fD, a_bX, a_bM, a_bW;
  logic [1:0]  a_state;
  logic [31:0] a_cnt;
  logic        b_sF, b_sD, b_sX, b_sM, b_fD, b_bX, b_bM, b_bW;
  logic [1:0]  b_state;
  logic [3:0]  b_cnt;
  logic [7:0]  a_ctrl;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_MEM  = 8'b1111_0001;
  localparam logic [7:0] C_MUL  = 8'b1110_0010;
  localparam logic [7:0] C_BR   = 8'b0000_1100;
  localparam logic [7:0] C_LU   = 8'b1100_0100;

  always #5 clk = ~clk;

  assign a_ctrl = {a_sF, a_sD, a_sX, a_sM, a_fD, a_bX, a_bM, a_bW};

  hazard_stall_controller #(.MUL_LAT(4), .CNT_W(32)) u_a (
    .i_clk(clk), .i_reset(reset),
    .i_rgS1_index_IF_ID(s1_idx), .i_rgS2_index_IF_ID(s2_idx),
    .i_rgS1_used_IF_ID(s1_used), .i_rgS2_used_IF_ID(s2_used),
    .i_rgD_index_ID_EX(rd_idx), .i_ID_EX_readMem(rd_mem), .i_ID_EX_writeRg(wr_rg),
    .i_ID_EX_isMul(is_mul), .i_branch_taken_EX(br_taken),
    .i_dcache_miss_M(miss), .i_dcache_ready(ready),
    .o_stall_F(a_sF), .o_stall_D(a_sD), .o_stall_X(a_sX), .o_stall_M(a_sM),
    .o_flush_D(a_fD), .o_bubble_X(a_bX), .o_bubble_M(a_bM), .o_bubble_W(a_bW),
    .o_ctrl_state(a_state), .o_stall_count(a_cnt)
  );

  hazard_stall_controller #(.MUL_LAT(4), .CNT_W(4)) u_b (
    .i_clk(clk), .i_reset(reset),
    .i_rgS1_index_IF_ID(s1_idx), .i_rgS2_index_IF_ID(s2_idx),
    .i_rgS1_used_IF_ID(s1_used), .i_rgS2_used_IF_ID(s2_used),
    .i_rgD_index_ID_EX(rd_idx), .i_ID_EX_readMem(rd_mem), .i_ID_EX_writeRg(wr_rg),
    .i_ID_EX_isMul(is_mul), .i_branch_taken_EX(br_taken),
    .i_dcache_miss_M(miss), .i_dcache_ready(ready),
    .o_stall_F(b_sF), .o_stall_D(b_sD), .o_stall_X(b_sX), .o_stall_M(b_sM),
    .o_flush_D(b_fD), .o_bubble_X(b_bX), .o_bubble_M(b_bM), .o_bubble_W(b_bW),
    .o_ctrl_state(b_state), .o_stall_count(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    {s1_idx, s2_idx, rd_idx} = 15'd0;
    {s1_used, s2_used, rd_mem, wr_rg, is_mul, br_taken, miss, ready} = 8'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lets combinational outputs settle, then checks the control vector and state.
  task automatic chk_ctrl(input string tag, input logic [7:0] exp_ctrl, input logic [1:0] exp_state);
    #1;
    chk({tag, "_ctrl"}, {24'd0, a_ctrl}, {24'd0, exp_ctrl});
    chk({tag, "_state"}, {30'd0, a_state}, {30'd0, exp_state});
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    miss = 1'b1;
    is_mul = 1'b1;
    chk_ctrl("reset_forced", C_NONE, 2'd0);
    chk("reset_cnt", a_cnt, 32'd0);
    chk("reset_cnt4", {28'd0, b_cnt}, 32'd0);
    idle();
    tick();
    reset = 1'b1;
    #1;

    // load x5 in EX, ID reads x5 as rs2
    {rd_mem, wr_rg, rd_idx} = {1'b1, 1'b1, 5'd5};
    {s1_idx, s1_used, s2_idx, s2_used} = {5'd3, 1'b1, 5'd5, 1'b1};
    chk_ctrl("lu_rs2", C_LU, 2'd0);
    tick();
    idle();
    chk_ctrl("lu_after", C_NONE, 2'd0);
    chk("lu_cnt", a_cnt, 32'd1);

    {rd_mem, wr_rg, rd_idx, s1_idx, s1_used} = {1'b1, 1'b1, 5'd0, 5'd0, 1'b1};
    chk_ctrl("lu_x0", C_NONE, 2'd0);
    {rd_idx, s1_used, s2_idx, s2_used} = {5'd7, 1'b0, 5'd7, 1'b0};
    chk_ctrl("lu_unused", C_NONE, 2'd0);
    {wr_rg, s1_idx, s1_used} = {1'b0, 5'd7, 1'b1};
    chk_ctrl("lu_nowrite", C_NONE, 2'd0);
    tick();

    // taken branch beats load-use
    {rd_mem, wr_rg, rd_idx, s1_idx, s1_used, br_taken} = {1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1};
    chk_ctrl("branch", C_BR, 2'd0);
    tick();
    idle();
    chk("branch_cnt", a_cnt, 32'd1);

    // multiply: 3 stall cycles, no restall while isMul lingers
    is_mul = 1'b1;
    chk_ctrl("mul_c0", C_MUL, 2'd0);
    tick();
    chk_ctrl("mul_c1", C_MUL, 2'd2);
    tick();
    chk_ctrl("mul_c2", C_MUL, 2'd2);
    tick();
    chk_ctrl("mul_norestall", C_NONE, 2'd0);
    chk("mul_cnt", a_cnt, 32'd4);
    tick();
    is_mul = 1'b0;
    ready = 1'b1;
    chk_ctrl("ready_in_run", C_NONE, 2'd0);
    ready = 1'b0;

    // d-cache miss with a load-use frozen behind it
    miss = 1'b1;
    chk_ctrl("miss_c10", C_MEM, 2'd0);
    tick();
    miss = 1'b0;
    chk_ctrl("miss_c11", C_MEM, 2'd1);
    tick();
    {rd_mem, wr_rg, rd_idx, s2_idx, s2_used} = {1'b1, 1'b1, 5'd9, 5'd9, 1'b1};
    chk_ctrl("miss_c12_lu", C_MEM, 2'd1);
    tick();
    tick();
    ready = 1'b1;
    chk_ctrl("miss_c14_ready", C_MEM, 2'd1);
    tick();
    ready = 1'b0;
    chk_ctrl("miss_c15_lu", C_LU, 2'd0);
    chk("miss_cnt", a_cnt, 32'd9);
    tick();
    idle();
    chk_ctrl("miss_done", C_NONE, 2'd0);
    chk("miss_lu_cnt", a_cnt, 32'd10);

    // reset in MUL_WAIT with counter at 1
    is_mul = 1'b1;
    tick();
    tick();
    chk_ctrl("mulrst_wait", C_MUL, 2'd2);
    reset = 1'b0;
    chk_ctrl("mulrst_forced", C_NONE, 2'd2);
    tick();
    reset = 1'b1;
    is_mul = 1'b0;
    chk_ctrl("mulrst_after", C_NONE, 2'd0);
    chk("mulrst_cnt", a_cnt, 32'd0);
    chk("mulrst_cnt4", {28'd0, b_cnt}, 32'd0);

    // 20-cycle miss saturates the 4-bit counter
    miss = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("sat_cnt32", a_cnt, 32'd20);
    chk("sat_cnt4", {28'd0, b_cnt}, 32'd15);
    chk("sat_state4", {30'd0, b_state}, 32'd1);
    ready = 1'b1;
    chk_ctrl("sat_ready", C_MEM, 2'd1);
    tick();
    idle();
    chk_ctrl("sat_done", C_NONE, 2'd0);
    chk("sat_hold4", {28'd0, b_cnt}, 32'd15);
    chk("sat_cnt32_end", a_cnt, 32'd21);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
